// File: rtl/msk_sbox_layer_seq_if.sv
// Handshake bundle between an S-box layer sequencer and its datapath/randomness source.
// The slave side is the sequencer; SW is the bundle index width.
interface msk_sbox_layer_seq_if #(
    parameter int SW = 1
);
    logic          start;
    logic          inverse_in;
    logic          rnd_valid;
    logic          rnd_ready;
    logic          sb_enable;
    logic          sb_inverse;
    logic [SW-1:0] in_sel;
    logic          wr_en;
    logic [SW-1:0] wr_sel;
    logic          busy;
    logic          done;

    modport master (
        output start, inverse_in, rnd_valid,
        input  rnd_ready, sb_enable, sb_inverse, in_sel, wr_en, wr_sel, busy, done
    );

    modport slave (
        input  start, inverse_in, rnd_valid,
        output rnd_ready, sb_enable, sb_inverse, in_sel, wr_en, wr_sel, busy, done
    );
endinterface

// File: rtl/msk_sbox_layer_seq.sv
// Sequencer feeding NB = 2**PDSBOX column bundles through a LAT-deep masked S-box unit.
// Define MSK_SBOX_SEQ_RND_STALL_EN to stall the pipeline whenever fresh randomness is absent.
module msk_sbox_layer_seq #(
    parameter int d      = 2,
    parameter int PDSBOX = 0,
    parameter int LAT    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    msk_sbox_layer_seq_if.slave  bus
);
    localparam int NB = 2 ** PDSBOX;
    localparam int SW = (PDSBOX > 1) ? PDSBOX : 1;
    localparam logic [SW-1:0] LAST = SW'(NB - 1);
    localparam int unused_shares = d;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]     state;
    logic [LAT-1:0] vld;
    logic [SW-1:0]  iss_cnt;
    logic [SW-1:0]  wb_cnt;
    logic           sb_inverse_q;
    logic           active;
    logic           sb_en;
    logic           wr_en_i;

    assign active = (state == FEED) || (state == DRAIN);

`ifdef MSK_SBOX_SEQ_RND_STALL_EN
    assign sb_en = active & bus.rnd_valid;
`else
    logic unused_rnd;
    assign unused_rnd = bus.rnd_valid;
    assign sb_en      = active;
`endif

    // A bundle leaves the unit when its token reaches the last stage and the pipe advances.
    assign wr_en_i = vld[LAT-1] & sb_en;

    assign bus.sb_enable  = sb_en;
    assign bus.rnd_ready  = sb_en;
    assign bus.sb_inverse = sb_inverse_q;
    assign bus.in_sel     = (state == FEED) ? iss_cnt : '0;
    assign bus.wr_en      = wr_en_i;
    assign bus.wr_sel     = wb_cnt;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            vld          <= '0;
            iss_cnt      <= '0;
            wb_cnt       <= '0;
            sb_inverse_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        iss_cnt      <= '0;
                        wb_cnt       <= '0;
                        sb_inverse_q <= bus.inverse_in;
                        state        <= FEED;
                    end
                end
                FEED, DRAIN: begin
                    // Everything holds on a stalled edge; tokens only move with the unit.
                    if (sb_en) begin
                        vld <= (vld << 1) | LAT'(state == FEED);
                        if (state == FEED) begin
                            if (iss_cnt == LAST) begin
                                iss_cnt <= '0;
                                state   <= DRAIN;
                            end else begin
                                iss_cnt <= iss_cnt + SW'(1);
                            end
                        end
                    end
                    if (wr_en_i) begin
                        if (wb_cnt == LAST) begin
                            wb_cnt <= '0;
                        end else begin
                            wb_cnt <= wb_cnt + SW'(1);
                        end
                        if ((state == DRAIN) && (wb_cnt == LAST)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msk_sbox_layer_seq.sv
// Self-checking bench for msk_sbox_layer_seq with three instances (PDSBOX = 0, 1, 2).
// Honours MSK_SBOX_SEQ_RND_STALL_EN so the same bench covers both builds.
module tb_msk_sbox_layer_seq;
    localparam int LAT = 3;
`ifdef MSK_SBOX_SEQ_RND_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msk_sbox_layer_seq_if #(.SW(1)) bus0 ();
    msk_sbox_layer_seq_if #(.SW(1)) bus1 ();
    msk_sbox_layer_seq_if #(.SW(2)) bus2 ();

    msk_sbox_layer_seq #(.d(2), .PDSBOX(0), .LAT(LAT)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    msk_sbox_layer_seq #(.d(2), .PDSBOX(1), .LAT(LAT)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    msk_sbox_layer_seq #(.d(2), .PDSBOX(2), .LAT(LAT)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic       busy, we, done, en, rdy, sbi;
        logic [1:0] in_sel, wr_sel;
    } out_t;

    typedef struct {
        logic       start, inv, rnd;
        logic       busy, we, done, en, rdy, sbi;
        logic [1:0] in_sel, wr_sel;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic s, input logic inv, input logic rnd);
        case (sel)
            0:       begin bus0.start = s; bus0.inverse_in = inv; bus0.rnd_valid = rnd; end
            1:       begin bus1.start = s; bus1.inverse_in = inv; bus1.rnd_valid = rnd; end
            default: begin bus2.start = s; bus2.inverse_in = inv; bus2.rnd_valid = rnd; end
        endcase
    endtask

    task automatic readOut(input int sel, output out_t o);
        case (sel)
            0: begin
                o.busy = bus0.busy; o.we = bus0.wr_en; o.done = bus0.done;
                o.en = bus0.sb_enable; o.rdy = bus0.rnd_ready; o.sbi = bus0.sb_inverse;
                o.in_sel = {1'b0, bus0.in_sel}; o.wr_sel = {1'b0, bus0.wr_sel};
            end
            1: begin
                o.busy = bus1.busy; o.we = bus1.wr_en; o.done = bus1.done;
                o.en = bus1.sb_enable; o.rdy = bus1.rnd_ready; o.sbi = bus1.sb_inverse;
                o.in_sel = {1'b0, bus1.in_sel}; o.wr_sel = {1'b0, bus1.wr_sel};
            end
            default: begin
                o.busy = bus2.busy; o.we = bus2.wr_en; o.done = bus2.done;
                o.en = bus2.sb_enable; o.rdy = bus2.rnd_ready; o.sbi = bus2.sb_inverse;
                o.in_sel = bus2.in_sel; o.wr_sel = bus2.wr_sel;
            end
        endcase
    endtask

    // Runs one layer and reports done latency in edges after the start-sampling edge.
    task automatic runLayer(input int sel, input logic inv, input int stall_from, input int stall_len,
                            input bit rand_rnd, output int done_at, output int writes,
                            output int order_err, output int dones, output int en_err,
                            output int inv_err, output bit timeout);
        out_t o;
        logic rnd;
        logic exp_en;
        bit   finished;
        done_at = -1; writes = 0; order_err = 0; dones = 0; en_err = 0; inv_err = 0;
        finished = 1'b0;
        @(negedge clk);
        applyStimulus(sel, 1'b1, inv, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rand_rnd) rnd = 1'($urandom_range(0, 1));
            else          rnd = !((k >= stall_from) && (k < stall_from + stall_len));
            applyStimulus(sel, 1'b0, inv, rnd);
            #1;
            readOut(sel, o);
            if (o.we) begin
                if (o.wr_sel != 2'(writes)) order_err++;
                writes++;
            end
            if (o.done) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            if (o.busy && !o.done) begin
                exp_en = STALL ? rnd : 1'b1;
                if ((o.en !== exp_en) || (o.rdy !== o.en)) en_err++;
            end
            if (o.busy && (o.sbi !== inv)) inv_err++;
            if (!o.busy && (dones > 0)) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk);
        end
        timeout = !finished;
        applyStimulus(sel, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkLayer(input string tag, input int nb, input int exp_done,
                              input logic inv, input int sel, input int stall_from,
                              input int stall_len, input bit rand_rnd);
        int done_at, writes, order_err, dones, en_err, inv_err;
        bit timeout;
        runLayer(sel, inv, stall_from, stall_len, rand_rnd, done_at, writes, order_err,
                 dones, en_err, inv_err, timeout);
        checkOutput({tag, " timeout"}, 32'(timeout), 32'd0);
        checkOutput({tag, " done latency"}, 32'(done_at), 32'(exp_done));
        checkOutput({tag, " write count"}, 32'(writes), 32'(nb));
        checkOutput({tag, " write order"}, 32'(order_err), 32'd0);
        checkOutput({tag, " done pulses"}, 32'(dones), 32'd1);
        checkOutput({tag, " enable/ready"}, 32'(en_err), 32'd0);
        checkOutput({tag, " sb_inverse"}, 32'(inv_err), 32'd0);
    endtask

    initial begin
        vec_t vecs[10];
        out_t o;
        int   late_we, late_done;

        // PDSBOX=2 layer with inverse set; a second start mid-layer must be ignored.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd2};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};

        rst = 1'b1;
        for (int s = 0; s < 3; s++) applyStimulus(s, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applyStimulus(2, vecs[i].start, vecs[i].inv, STALL ? 1'b1 : vecs[i].rnd);
            #1;
            readOut(2, o);
            checkOutput($sformatf("vec%0d busy", i), 32'(o.busy), 32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d in_sel", i), 32'(o.in_sel), 32'(vecs[i].in_sel));
            checkOutput($sformatf("vec%0d wr_en", i), 32'(o.we), 32'(vecs[i].we));
            checkOutput($sformatf("vec%0d wr_sel", i), 32'(o.wr_sel), 32'(vecs[i].wr_sel));
            checkOutput($sformatf("vec%0d done", i), 32'(o.done), 32'(vecs[i].done));
            checkOutput($sformatf("vec%0d sb_enable", i), 32'(o.en), 32'(vecs[i].en));
            checkOutput($sformatf("vec%0d rnd_ready", i), 32'(o.rdy), 32'(vecs[i].rdy));
            checkOutput($sformatf("vec%0d sb_inverse", i), 32'(o.sbi), 32'(vecs[i].sbi));
        end
        applyStimulus(2, 1'b0, 1'b0, 1'b1);

        checkLayer("nb1 inverse", 1, 1 + LAT, 1'b1, 0, 0, 0, 1'b0);
        checkLayer("nb4 stall", 4, 4 + LAT + (STALL ? 2 : 0), 1'b0, 2, 2, 2, 1'b0);
        checkLayer("nb2 random rnd", 2, 2 + LAT, 1'b1, 1, 0, 0, !STALL);

        // Reset while PDSBOX=2 is draining (cycle 6 after the start cycle).
        @(negedge clk);
        applyStimulus(2, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        applyStimulus(2, 1'b0, 1'b1, 1'b1);
        #1;
        readOut(2, o);
        checkOutput("pre-reset busy", 32'(o.busy), 32'd1);
        checkOutput("pre-reset wr_sel", 32'(o.wr_sel), 32'd2);
        rst = 1'b1;
        #1;
        readOut(2, o);
        checkOutput("reset busy", 32'(o.busy), 32'd0);
        checkOutput("reset wr_en", 32'(o.we), 32'd0);
        checkOutput("reset wr_sel", 32'(o.wr_sel), 32'd0);
        checkOutput("reset in_sel", 32'(o.in_sel), 32'd0);
        checkOutput("reset done", 32'(o.done), 32'd0);
        checkOutput("reset sb_enable", 32'(o.en), 32'd0);
        checkOutput("reset rnd_ready", 32'(o.rdy), 32'd0);
        checkOutput("reset sb_inverse", 32'(o.sbi), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        late_we = 0;
        late_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            readOut(2, o);
            if (o.we) late_we++;
            if (o.done) late_done++;
        end
        checkOutput("post-reset stray wr_en", 32'(late_we), 32'd0);
        checkOutput("post-reset stray done", 32'(late_done), 32'd0);

        checkLayer("nb4 after reset", 4, 4 + LAT, 1'b0, 2, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/msk_sbox_layer_seq.md
MSK_SBOX_LAYER_SEQ -- requirements
Module: msk_sbox_layer_seq

Interface
REQ-001 SHALL have parameter d, default 2, number of masking shares (pass-through only, no logic depends on it).
REQ-002 SHALL have parameter PDSBOX, default 0, giving NB = 2**PDSBOX column bundles per S-box layer.
REQ-003 SHALL have parameter LAT, default 3, the S-box unit latency in enabled clock edges.
REQ-004 SHALL use one clock and an asynchronous active-high reset: clk input 1 (rising-edge clock) and rst input 1 (asynchronous, active-high reset).
REQ-005 start input 1: one-cycle request to process one S-box layer.
REQ-006 inverse_in input 1: layer direction, sampled with start.
REQ-007 rnd_valid input 1: fresh randomness is present on the S-box rnd1/rnd2 buses this cycle.
REQ-008 rnd_ready output 1: randomness is consumed at this edge.
REQ-009 sb_enable output 1: drives the S-box unit enable (pipeline advance).
REQ-010 sb_inverse output 1: drives the S-box unit inverse.
REQ-011 in_sel output SW: index of the bundle muxed into the S-box unit, where SW = max(1,PDSBOX).
REQ-012 wr_en output 1: the S-box unit output bundle is written back this edge.
REQ-013 wr_sel output SW: bundle index for the write-back.
REQ-014 busy output 1: a layer is in progress.
REQ-015 done output 1: one-cycle pulse when a layer completes.

Function
REQ-016 The FSM SHALL have states IDLE, FEED, DRAIN and FIN.
REQ-017 In IDLE, start SHALL load iss_cnt=0 and wb_cnt=0, latch inverse_in into sb_inverse, and move the FSM to FEED; start SHALL be ignored in all other states.
REQ-018 In FEED and DRAIN, sb_enable SHALL equal rnd_valid, rnd_ready SHALL equal sb_enable, and in IDLE and FIN both SHALL be 0.
REQ-019 In FEED, in_sel SHALL equal iss_cnt, and each edge with sb_enable=1 SHALL push a valid token into a LAT-deep valid shift register vld[0..LAT-1] and increment iss_cnt.
REQ-020 In DRAIN, a 0 token SHALL be pushed on each enabled edge.
REQ-021 vld SHALL shift only on edges with sb_enable=1; with sb_enable=0 every counter and vld SHALL hold (full stall).
REQ-022 wr_en SHALL equal vld[LAT-1] AND sb_enable, wr_sel SHALL equal wb_cnt, and wb_cnt SHALL increment on each edge with wr_en=1.
REQ-023 FEED SHALL go to DRAIN on the enabled edge that issues bundle NB-1, with iss_cnt wrapping to 0 without overflow hazard.
REQ-024 DRAIN SHALL go to FIN on the edge where wr_en=1 and wb_cnt=NB-1.
REQ-025 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 busy SHALL be 1 in FEED, DRAIN and FIN, and 0 in IDLE.
REQ-027 With no stalls, a layer SHALL take NB+LAT cycles from the cycle after start to done, with writes on the edges LAT..NB+LAT-1 after the first issue.
REQ-028 For PDSBOX=0 (NB=1), in_sel and wr_sel SHALL be constant 0 and the FSM SHALL go straight from the FEED edge to DRAIN.
REQ-029 Exactly NB writes SHALL occur per layer, in order 0..NB-1, never duplicated, regardless of the stall pattern.

Reset
REQ-030 Asserting rst at any time, including mid-layer, SHALL asynchronously force IDLE, clear vld, iss_cnt, wb_cnt and sb_inverse, and drive all outputs to 0.
REQ-031 A layer interrupted by rst SHALL produce no done pulse and no further wr_en.

Configuration
REQ-032 The feature SHALL be controlled by the macro MSK_SBOX_SEQ_RND_STALL_EN.
REQ-033 With MSK_SBOX_SEQ_RND_STALL_EN defined, behaviour SHALL be as specified above, with sb_enable gated by rnd_valid.
REQ-034 Without MSK_SBOX_SEQ_RND_STALL_EN, rnd_valid SHALL be ignored, sb_enable SHALL be 1 throughout FEED and DRAIN, and rnd_ready SHALL equal sb_enable, so the layer always takes NB+LAT cycles.

Verification
REQ-035 PDSBOX=2, LAT=3, rnd_valid=1, start pulse -> in_sel 0,1,2,3 on consecutive cycles; wr_en with wr_sel 0..3 on cycles 4..7 after start; done on cycle 8.
REQ-036 PDSBOX=2, rnd_valid held low for 2 cycles after issue 1 -> all counters and vld frozen; writes still occur exactly once each for 0..3; done 2 cycles later than in REQ-035.
REQ-037 PDSBOX=0 with inverse_in=1 -> sb_inverse=1 during the layer; one write with wr_sel=0; done 4 cycles after start.
REQ-038 rst asserted during DRAIN of a PDSBOX=2 layer -> outputs 0 immediately; no done pulse; next start runs a full, correct layer.
REQ-039 start asserted while busy=1 -> ignored; sb_inverse unchanged; exactly one done pulse.
REQ-040 Built without MSK_SBOX_SEQ_RND_STALL_EN, rnd_valid toggling randomly, PDSBOX=1 -> sb_enable stays high; done exactly 5 cycles after start.
